instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 153 +++++++++++++++
 tb/tb_instruction_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// instruction_loader
//
// Takes RV32I field bundles (R-ALU, I-ALU, LOAD, STORE), encodes each into a
// 32-bit instruction word and writes it to instruction memory at consecutive
// word addresses from a base captured on start. After DEPTH words the loader
// reports full until the next start.
//
// Optional feature: define INSTRUCTION_LOADER_CHECK_EN to reject malformed
// bundles (bad R funct7, reserved LOAD/STORE funct3). A rejected bundle
// completes its handshake, is not written, and pulses err for one cycle.
// With the macro undefined every accepted bundle is written and err stays 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, base_addr    open a session at base_addr (IDLE or FULL only)
//   in_valid, in_ready  bundle handshake (in_ready only in READY)
//   fmt, rd, rs1, rs2,
//   funct3, funct7, imm instruction fields; fmt 0=R 1=I 2=LOAD 3=STORE
//   mem_we, mem_addr,
//   mem_wdata, mem_ack  memory write port; request held until mem_ack
//   word_count          words written in the current session
//   full                DEPTH words written
//   err                 one-cycle pulse on a rejected bundle
module instruction_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [15:0] word_count,
  output logic        full,
  output logic        err
);

  localparam logic [15:0] DepthW = 16'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReady, StWrite, StFull} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  logic [31:0] encoded;
  logic        bundle_bad;
  logic [15:0] count_inc;

  // Field packing; unused fields of each format are simply not referenced.
  always_comb begin
    encoded = '0;
    unique case (fmt)
      2'd0: encoded = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      2'd1: encoded = {imm, rs1, funct3, rd, 7'b0010011};
      2'd2: encoded = {imm, rs1, funct3, rd, 7'b0000011};
      2'd3: encoded = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      default: encoded = '0;
    endcase
  end

`ifdef INSTRUCTION_LOADER_CHECK_EN
  always_comb begin
    bundle_bad = 1'b0;
    unique case (fmt)
      2'd0: bundle_bad = (funct7 != 7'h00) && (funct7 != 7'h20);
      2'd2: bundle_bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      2'd3: bundle_bad = (funct3 > 3'd2);
      default: bundle_bad = 1'b0;
    endcase
  end
`else
  assign bundle_bad = 1'b0;
`endif

  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle, StFull: begin
        if (start) begin
          state_d = StReady;
          addr_d  = base_addr;
          count_d = '0;
        end
      end
      StReady: begin
        if (in_valid) begin
          if (bundle_bad) begin
            // Handshake completes but nothing is written.
            err_d = 1'b1;
          end else begin
            wdata_d = encoded;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (mem_ack) begin
          addr_d  = addr_q + 32'd4;  // wraps naturally at 2^32
          count_d = count_inc;
          state_d = (count_inc == DepthW) ? StFull : StReady;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // drops mem_we without waiting for a clock edge.
  assign in_ready   = (state_q == StReady);
  assign mem_we     = (state_q == StWrite);
  assign full       = (state_q == StFull);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed + randomized bench for instruction_loader. A reference model of
// address, count, last written word and full flag is updated from the
// behavioural rules; instruction encoding is computed with shifts and ORs.
module tb_instruction_loader;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [11:0] imm = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] word_count;
  logic        full;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          m_count = 0;
  logic        m_full = 1'b0;

  instruction_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .word_count (word_count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] encode(input int f, input int d, input int s1, input int s2,
                                         input int f3, input int f7, input int im);
    int w;
    case (f)
      0: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 'h33;
      1: w = (im << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 'h13;
      2: w = (im << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 'h03;
      default: w = ((im >> 5) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                   | ((im & 31) << 7) | 'h23;
    endcase
    return 32'(w);
  endfunction

  function automatic bit is_bad(input int f, input int f3, input int f7);
`ifdef INSTRUCTION_LOADER_CHECK_EN
    if (f == 0) return !(f7 == 0 || f7 == 'h20);
    if (f == 2) return (f3 == 3 || f3 == 6 || f3 == 7);
    if (f == 3) return (f3 > 2);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    chk_w({tag, "_addr"}, mem_addr, m_addr);
    chk_w({tag, "_wdata"}, mem_wdata, m_wdata);
    chk_w({tag, "_count"}, 32'(word_count), 32'(m_count));
    chk_b({tag, "_full"}, full, m_full);
  endtask

  task automatic do_start(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_addr = base;
    m_count = 0;
    m_full = 1'b0;
    chk_b("start_ready", in_ready, 1'b1);
    check_outputs("start");
  endtask

  // Present one bundle in READY, then hold off mem_ack for `delay` cycles.
  task automatic send_bundle(input int f, input int d, input int s1, input int s2,
                             input int f3, input int f7, input int im,
                             input int delay, input bit noise);
    chk_b("pre_ready", in_ready, 1'b1);
    fmt = 2'(f); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
    funct3 = 3'(f3); funct7 = 7'(f7); imm = 12'(im);
    in_valid = 1'b1;
    mem_ack = noise ? 1'($urandom) : 1'b0;  // ack outside WRITE is ignored
    tick();
    in_valid = 1'b0;
    mem_ack = 1'b0;
    if (is_bad(f, f3, f7)) begin
      chk_b("rej_err", err, 1'b1);
      chk_b("rej_we", mem_we, 1'b0);
      chk_b("rej_ready", in_ready, 1'b1);
      check_outputs("rej");
      tick();
      chk_b("rej_err_drop", err, 1'b0);
      return;
    end
    m_wdata = encode(f, d, s1, s2, f3, f7, im);
    chk_b("wr_err", err, 1'b0);
    for (int i = 0; i <= delay; i++) begin
      chk_b("wr_we", mem_we, 1'b1);
      chk_b("wr_ready", in_ready, 1'b0);
      check_outputs("wr");
      if (noise) begin
        in_valid = 1'($urandom);
        fmt = 2'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom); imm = 12'($urandom);
        start = 1'($urandom);
        base_addr = $urandom;
      end
      mem_ack = (i == delay);
      tick();
    end
    mem_ack = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    m_addr = m_addr + 32'd4;
    m_count++;
    m_full = (m_count == int'(DEPTH));
    chk_b("ack_we", mem_we, 1'b0);
    chk_b("ack_ready", in_ready, !m_full);
    check_outputs("ack");
  endtask

  initial begin
    int f, f7;
    // Reset values, asynchronously applied
    #2;
    chk_b("rst_ready", in_ready, 1'b0);
    chk_b("rst_we", mem_we, 1'b0);
    chk_b("rst_err", err, 1'b0);
    check_outputs("rst");
    tick();
    rst_n = 1'b1;

    // Stay IDLE without start, whatever else toggles
    in_valid = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_b("idle_ready", in_ready, 1'b0);
      chk_b("idle_we", mem_we, 1'b0);
      check_outputs("idle");
    end
    in_valid = 1'b0;
    mem_ack = 1'b0;

    // First R bundle, known word
    do_start(32'h100);
    base_addr = 32'hDEAD0000;  // start in READY is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_b("ready_start_ign", in_ready, 1'b1);
    check_outputs("ready_start_ign");
    send_bundle(0, 1, 2, 3, 0, 'h20, 'hABC, 0, 0);
    chk_w("r_word_const", m_wdata, 32'h403100B3);

    // STORE held 5 cycles before ack; this fills the session
    send_bundle(3, 9, 2, 5, 2, 'h55, 'h7FC, 5, 1);
    chk_w("s_word_const", mem_wdata, 32'h7E512E23);

    // FULL ignores bundles and acks
    in_valid = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_b("full_ready", in_ready, 1'b0);
      chk_b("full_we", mem_we, 1'b0);
      check_outputs("full");
    end
    in_valid = 1'b0;
    mem_ack = 1'b0;

    // Address wrap across 2^32
    do_start(32'hFFFFFFFC);
    send_bundle(1, 3, 4, 0, 0, 0, 'h123, 1, 0);
    chk_w("wrap_addr0", mem_addr, 32'h0);
    send_bundle(1, 5, 6, 0, 7, 0, 'hFFF, 0, 0);

    // Randomized sessions with noise on ignored inputs
    for (int s = 0; s < 12; s++) begin
      do_start($urandom & 32'hFFFFFFFC);
      for (int n = 0; n < 20 && m_count < int'(DEPTH); n++) begin
        f = int'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0: f7 = 0;
          1: f7 = 'h20;
          default: f7 = int'($urandom_range(0, 127));
        endcase
        send_bundle(f, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), f7,
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)), 1);
      end
    end

    // Restart from FULL at base 0, then LOAD funct3=7
    if (!m_full) begin
      chk_b("not_full_before_restart", full, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_addr = '0; m_wdata = '0; m_count = 0; m_full = 1'b0;
    end
    do_start(32'h0);
    send_bundle(2, 7, 8, 0, 7, 0, 'h010, 1, 0);

    // Reset in the middle of a write
    if (m_full) do_start(32'h40);
    chk_b("pre_rstw_ready", in_ready, 1'b1);
    fmt = 2'd1; rd = 5'd10; rs1 = 5'd11; funct3 = 3'd0; imm = 12'h321;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_b("rstw_we_before", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    m_addr = '0; m_wdata = '0; m_count = 0; m_full = 1'b0;
    chk_b("rstw_we", mem_we, 1'b0);
    chk_b("rstw_ready", in_ready, 1'b0);
    chk_b("rstw_err", err, 1'b0);
    check_outputs("rstw");
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_b("post_rst_we", mem_we, 1'b0);
      chk_b("post_rst_ready", in_ready, 1'b0);
      check_outputs("post_rst");
    end
    in_valid = 1'b0;
    mem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
